// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and default shift count.
// Optional single-step feature is enabled in the top by defining SHIFT_SEQ_STEP_EN.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } shift_state_t;

    localparam int N_SHIFTS_DEFAULT = 8;

endpackage

// File: rtl/shift_seq_ctrl_counter.sv
// Shift counter: synchronous clear/enable, asynchronous reset, and a terminal
// flag that fires during the enabled cycle that completes the N_SHIFTS-th shift.
module shift_counter
    import shift_ctrl_pkg::*;
#(
    parameter int N_SHIFTS = N_SHIFTS_DEFAULT,
    parameter int CNT_W    = $clog2(N_SHIFTS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over enable; free-running wrap is what continuous mode relies on.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == CNT_W'(N_SHIFTS - 1)) & en_i;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Counter-based sequencer for shift-register datapaths: fixed or continuous mode,
// Busy/Done status and a visible shift count. Define SHIFT_SEQ_STEP_EN for the Step port.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int N_SHIFTS = N_SHIFTS_DEFAULT,
    localparam int CNT_W    = $clog2(N_SHIFTS + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic             Mode,
`ifdef SHIFT_SEQ_STEP_EN
    input  logic             Step,
`endif
    output logic             Shift_En,
    output logic             Ld_A,
    output logic             Ld_B,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Shift_Cnt,
    output logic [1:0]       Dbg_State
);

    shift_state_t state_q, state_d;
    logic         mode_q, mode_d;
    logic         done_q, done_d;

    logic cnt_clr, cnt_en, cnt_term;
    logic shift_en, ld_a, ld_b, busy;
    logic step_ok;

`ifdef SHIFT_SEQ_STEP_EN
    assign step_ok = Step;
`else
    assign step_ok = 1'b1;
`endif

    shift_counter #(
        .N_SHIFTS (N_SHIFTS),
        .CNT_W    (CNT_W)
    ) u_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (Shift_Cnt),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        shift_en = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ld_a = LoadA;
                ld_b = LoadB;
                if (Execute) begin
                    state_d = S_RUN;
                    cnt_clr = 1'b1;
                    mode_d  = Mode;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                // Continuous mode leaves on the first low Execute without shifting.
                if (mode_q) begin
                    if (!Execute) begin
                        state_d = S_HALT;
                    end else begin
                        cnt_en = step_ok;
                    end
                end else begin
                    cnt_en = step_ok;
                    if (cnt_term) begin
                        state_d = S_HALT;
                    end
                end
                shift_en = cnt_en;
            end
            S_HALT: begin
                if (!Execute) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_HALT) && (state_q != S_HALT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Enables are gated so nothing reaches the datapath while reset is asserted.
    assign Shift_En  = shift_en & ~Reset;
    assign Ld_A      = ld_a & ~Reset;
    assign Ld_B      = ld_b & ~Reset;
    assign Busy      = busy & ~Reset;
    assign Done      = done_q;
    assign Dbg_State = state_q;

endmodule
